alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU, the successor to the fixed 32-bit add/sub ALU.

---
 rtl/alu_mc_if.sv | 25 ++
 rtl/alu_mc.sv | 159 +++++++++++++++
 tb/tb_alu_mc.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// Handshake bundle between the register-read stage and the multi-cycle ALU.
// The master drives operands and takes results; the slave is the ALU.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_in_a;
    logic [WIDTH-1:0] alu_in_b;
    logic [2:0]       opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       flags;

    modport master (
        output in_valid, alu_in_a, alu_in_b, opcode, out_ready,
        input  in_ready, out_valid, alu_res, flags
    );

    modport slave (
        input  in_valid, alu_in_a, alu_in_b, opcode, out_ready,
        output in_ready, out_valid, alu_res, flags
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/compare ops plus an iterative
// shift-add multiply, with valid/ready on both sides and {N,Z,C,V} flags.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst,
    alu_mc_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [3:0]           flags_q, flags_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]     b_eff_s;
    logic [WIDTH:0]       sum_s;
    logic [WIDTH-1:0]     op_res_s;
    logic                 op_c_s;
    logic                 op_v_s;
    logic [2*WIDTH-1:0]   acc_next_s;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        return {r[WIDTH-1], (r == {WIDTH{1'b0}}), c, v};
    endfunction

    // Single-cycle datapath evaluated directly on the operand inputs at accept.
    always_comb begin
        b_eff_s  = (bus.opcode == OP_SUB) ? ~bus.alu_in_b : bus.alu_in_b;
        sum_s    = {1'b0, bus.alu_in_a} + {1'b0, b_eff_s}
                 + {{WIDTH{1'b0}}, (bus.opcode == OP_SUB)};
        op_res_s = {WIDTH{1'b0}};
        op_c_s   = 1'b0;
        op_v_s   = 1'b0;
        case (bus.opcode)
            OP_ADD, OP_SUB: begin
                op_res_s = sum_s[WIDTH-1:0];
                op_c_s   = sum_s[WIDTH];
                // SUB feeds ~B, so one sign rule covers both directions
                op_v_s   = (bus.alu_in_a[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                           (sum_s[WIDTH-1] != bus.alu_in_a[WIDTH-1]);
            end
            OP_AND: op_res_s = bus.alu_in_a & bus.alu_in_b;
            OP_OR:  op_res_s = bus.alu_in_a | bus.alu_in_b;
            OP_XOR: op_res_s = bus.alu_in_a ^ bus.alu_in_b;
            OP_SLT: op_res_s = {{(WIDTH-1){1'b0}},
                                ($signed(bus.alu_in_a) < $signed(bus.alu_in_b))};
            default: op_res_s = {WIDTH{1'b0}};
        endcase
    end

    assign acc_next_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    // Next-state logic for the FSM and all datapath registers.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        res_d       = res_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.opcode == OP_MUL) begin
                        state_d  = ST_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, bus.alu_in_a};
                        mplier_d = bus.alu_in_b;
                        acc_d    = {(2*WIDTH){1'b0}};
                        cnt_d    = {CNT_W{1'b0}};
                    end else begin
                        state_d     = ST_HOLD;
                        res_d       = op_res_s;
                        flags_d     = make_flags(op_res_s, op_c_s, op_v_s);
                        out_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                // One multiplier bit per cycle, LSB first
                acc_d    = acc_next_s;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = ST_HOLD;
                    res_d       = acc_next_s[WIDTH-1:0];
                    flags_d     = make_flags(acc_next_s[WIDTH-1:0], 1'b0,
                                             |acc_next_s[2*WIDTH-1:WIDTH]);
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight or held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mcand_q     <= {(2*WIDTH){1'b0}};
            acc_q       <= {(2*WIDTH){1'b0}};
            mplier_q    <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.alu_res   = res_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32; expected values are hand-computed.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    alu_mc_if #(.WIDTH(32)) bus ();
    alu_mc #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND = 3'b010, OR = 3'b011;
    localparam logic [2:0] XOR = 3'b100, SLT = 3'b101, MUL = 3'b110, RSV = 3'b111;

    // Arithmetic vectors: op, a, b, expected result, expected {N,Z,C,V}
    logic [2:0]  ar_op  [0:4] = '{SUB, ADD, ADD, SUB, SUB};
    logic [31:0] ar_a   [0:4] = '{32'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
    logic [31:0] ar_b   [0:4] = '{32'd5, 32'd1, 32'd1, 32'd3, 32'd1};
    logic [31:0] ar_res [0:4] = '{32'hFFFF_FFFE, 32'h8000_0000, 32'd0, 32'd2, 32'h7FFF_FFFF};
    logic [3:0]  ar_fl  [0:4] = '{4'b1000, 4'b1001, 4'b0110, 4'b0010, 4'b0011};

    // Logic / compare / reserved vectors
    logic [2:0]  lg_op  [0:6] = '{SLT, SLT, SLT, AND, OR, XOR, RSV};
    logic [31:0] lg_a   [0:6] = '{32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'hF0F0_F0F0,
                                  32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'd3};
    logic [31:0] lg_b   [0:6] = '{32'd1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFF00_FF00,
                                  32'hFF00_FF00, 32'hFF00_FF00, 32'd4};
    logic [31:0] lg_res [0:6] = '{32'd1, 32'd0, 32'd1, 32'hF000_F000,
                                  32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'd0};
    logic [3:0]  lg_fl  [0:6] = '{4'b0000, 4'b0100, 4'b0000, 4'b1000,
                                  4'b1000, 4'b0000, 4'b0100};

    // Multiply vectors
    logic [31:0] mu_a   [0:2] = '{32'h0001_0000, 32'd6, 32'hFFFF_FFFF};
    logic [31:0] mu_b   [0:2] = '{32'h0001_0000, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] mu_res [0:2] = '{32'd0, 32'd42, 32'd1};
    logic [3:0]  mu_fl  [0:2] = '{4'b0101, 4'b0000, 4'b0001};

    // Present one op for the accept edge, scramble inputs, then count edges until out_valid.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        bus.opcode   = op;
        bus.alu_in_a = a;
        bus.alu_in_b = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.alu_in_a = 32'hDEAD_BEEF;
        bus.alu_in_b = 32'h1234_5678;
        bus.opcode   = SUB;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.alu_res !== 32'd0 || bus.flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b res=%h flags=%b, want 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.alu_res, bus.flags);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        bus.out_ready = 1'b1;
        run_op(ADD, 32'd7, 32'd5, lat);
        n_tests++;
        if (lat !== 1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_latency: lat=%0d in_ready=%b, want 1 0", lat, bus.in_ready);
        end
        n_tests++;
        if (bus.alu_res !== 32'd12 || bus.flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL add_result: res=%h flags=%b, want 0000000c 0000", bus.alu_res, bus.flags);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add_idle: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_arith();
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(ar_op[i], ar_a[i], ar_b[i], lat);
            n_tests++;
            if (lat !== 1 || bus.alu_res !== ar_res[i] || bus.flags !== ar_fl[i]) begin
                n_fail++;
                $display("FAIL arith[%0d]: lat=%0d res=%h flags=%b, want 1 %h %b",
                         i, lat, bus.alu_res, bus.flags, ar_res[i], ar_fl[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_logic();
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_op(lg_op[i], lg_a[i], lg_b[i], lat);
            n_tests++;
            if (lat !== 1 || bus.alu_res !== lg_res[i] || bus.flags !== lg_fl[i]) begin
                n_fail++;
                $display("FAIL logic[%0d]: lat=%0d res=%h flags=%b, want 1 %h %b",
                         i, lat, bus.alu_res, bus.flags, lg_res[i], lg_fl[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mul();
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(MUL, mu_a[i], mu_b[i], lat);
            n_tests++;
            if (lat !== 33) begin
                n_fail++;
                $display("FAIL mul_latency[%0d]: got %0d cycles, want 33", i, lat);
            end
            n_tests++;
            if (bus.alu_res !== mu_res[i] || bus.flags !== mu_fl[i]) begin
                n_fail++;
                $display("FAIL mul_result[%0d]: res=%h flags=%b, want %h %b",
                         i, bus.alu_res, bus.flags, mu_res[i], mu_fl[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        bus.out_ready = 1'b0;
        run_op(ADD, 32'd9, 32'd10, lat);
        bus.in_valid = 1'b1;
        bus.opcode   = MUL;
        bus.alu_in_a = 32'd3;
        bus.alu_in_b = 32'd3;
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.alu_res !== 32'd19 || bus.flags !== 4'b0000) bad++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (lat !== 1 || bad !== 0) begin
            n_fail++;
            $display("FAIL bp_stable: lat=%0d unstable_cycles=%0d, want 1 0", lat, bad);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, want 0 1", bus.out_valid, bus.in_ready);
        end
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL bp_not_queued: out_valid high %0d cycles, want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.out_ready = 1'b1;
        run_op(ADD, 32'd1, 32'd2, lat);
        bus.in_valid = 1'b1;
        bus.opcode   = ADD;
        bus.alu_in_a = 32'd100;
        bus.alu_in_b = 32'd100;
        @(posedge clk); #1;
        n_tests++;
        if (lat !== 1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_hold_no_accept: lat=%0d out_valid=%b in_ready=%b, want 1 0 1",
                     lat, bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.alu_res !== 32'd200) begin
            n_fail++;
            $display("FAIL b2b_second: out_valid=%b res=%h, want 1 000000c8", bus.out_valid, bus.alu_res);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int seen = 0;
        bus.out_ready = 1'b1;
        bus.opcode    = MUL;
        bus.alu_in_a  = 32'd6;
        bus.alu_in_b  = 32'd7;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.alu_res !== 32'd0 || bus.flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_mul: in_ready=%b out_valid=%b res=%h flags=%b, want 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.alu_res, bus.flags);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_mul_dropped: out_valid high %0d cycles, want 0", seen);
        end
        bus.out_ready = 1'b0;
        run_op(ADD, 32'd4, 32'd4, lat);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_tests++;
        if (lat !== 1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.alu_res !== 32'd0 || bus.flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_in_hold: lat=%0d in_ready=%b out_valid=%b res=%h flags=%b, want 1 1 0 0 0000",
                     lat, bus.in_ready, bus.out_valid, bus.alu_res, bus.flags);
        end
        bus.out_ready = 1'b1;
        run_op(ADD, 32'd1, 32'd1, lat);
        n_tests++;
        if (lat !== 1 || bus.alu_res !== 32'd2 || bus.flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_then_add: lat=%0d res=%h flags=%b, want 1 00000002 0000",
                     lat, bus.alu_res, bus.flags);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.opcode    = 3'b000;
        bus.alu_in_a  = 32'd0;
        bus.alu_in_b  = 32'd0;
        test_reset();
        test_add();
        test_arith();
        test_logic();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
